// File: rtl/apb_uart_irq_ctrl.sv
// ---------------------------------------------------------------------------
// apb_uart_irq_ctrl
//   16550-style UART interrupt controller. Tracks the four interrupt sources
//   (receiver line status, receive data available / character timeout,
//   transmitter holding register empty, modem status), prioritises the
//   enabled ones and presents the result as a registered IIR code.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   ier_i[3:0]          enables: [0] RDA/CTI, [1] THRE, [2] RLS, [3] MS
//   fifo_en_i           FIFO mode (threshold compare + timeout active)
//   trigger_level_i     RX trigger level select
//   rx_elements_i       RX FIFO occupancy
//   tx_elements_i       TX FIFO occupancy
//   rx_push_i/rx_pop_i  RX FIFO activity strobes
//   tx_push_i           TX FIFO write strobe
//   bit_tick_i          one pulse per serial bit time
//   line_err_i          line error event pulse
//   msr_change_i        modem status change pulse
//   lsr_rd_i/msr_rd_i/iir_rd_i  register read strobes
//   iir_o               registered interrupt identification
//   interrupt_o         interrupt request (low when iir_o = 0001)
// ---------------------------------------------------------------------------
module apb_uart_irq_ctrl #(
  parameter int RX_FIFO_DEPTH = 16,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [3:0]                       ier_i,
  input  logic                             fifo_en_i,
  input  logic [1:0]                       trigger_level_i,
  input  logic [$clog2(RX_FIFO_DEPTH):0]   rx_elements_i,
  input  logic [$clog2(TX_FIFO_DEPTH):0]   tx_elements_i,
  input  logic                             rx_push_i,
  input  logic                             rx_pop_i,
  input  logic                             tx_push_i,
  input  logic                             bit_tick_i,
  input  logic                             line_err_i,
  input  logic                             msr_change_i,
  input  logic                             lsr_rd_i,
  input  logic                             msr_rd_i,
  input  logic                             iir_rd_i,
  output logic [3:0]                       iir_o,
  output logic                             interrupt_o
);

  localparam int RXW = $clog2(RX_FIFO_DEPTH) + 1;
  localparam int TXW = $clog2(TX_FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_TICKS);

  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRE = 4'b0010;
  localparam logic [3:0] IIR_MS   = 4'b0000;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  logic [RXW-1:0] rx_thr;
  logic           rda_cond;
  logic           rx_empty;
  logic           tx_empty;

  logic           rls_pend;
  logic           ms_pend;
  logic           cti_pend;
  logic           thre_pend;
  logic [CW-1:0]  to_cnt;
  logic [TXW-1:0] tx_prev;
  logic           ier_thre_q;

  logic           to_clr;
  logic           cti_clr;
  logic           thre_set;
  logic           thre_clr;
  logic [3:0]     iir_nxt;

  // RX trigger threshold
  always_comb begin
    rx_thr = RXW'(1);
    unique case (trigger_level_i)
      2'd0: rx_thr = RXW'(1);
      2'd1: rx_thr = RXW'(RX_FIFO_DEPTH / 4);
      2'd2: rx_thr = RXW'(RX_FIFO_DEPTH / 2);
      2'd3: rx_thr = RXW'(RX_FIFO_DEPTH - 2);
      default: rx_thr = RXW'(1);
    endcase
  end

  assign rx_empty = (rx_elements_i == '0);
  assign tx_empty = (tx_elements_i == '0);

  // RDA is a live level, never latched
  assign rda_cond = fifo_en_i ? (rx_elements_i >= rx_thr) : !rx_empty;

  // Any RX activity or an empty FIFO restarts the character timeout
  assign cti_clr = rx_push_i | rx_pop_i | rx_empty;
  assign to_clr  = cti_clr | ~fifo_en_i;

  // THRE fires on the TX FIFO draining, or on enabling THRE while empty
  assign thre_set = tx_empty & ((tx_prev != '0) | (ier_i[1] & ~ier_thre_q));
  assign thre_clr = tx_push_i | (iir_rd_i & (iir_o == IIR_THRE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (to_clr) begin
      to_cnt <= '0;
    end else if (bit_tick_i && (to_cnt != TO_MAX)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rls_pend   <= 1'b0;
      ms_pend    <= 1'b0;
      cti_pend   <= 1'b0;
      thre_pend  <= 1'b0;
      tx_prev    <= '0;
      ier_thre_q <= 1'b0;
    end else begin
      // set wins for the event-driven status sources
      rls_pend   <= line_err_i   | (rls_pend & ~lsr_rd_i);
      ms_pend    <= msr_change_i | (ms_pend  & ~msr_rd_i);
      // clear wins for the FIFO-driven sources
      cti_pend   <= ~cti_clr  & (cti_pend  | (to_cnt == TO_MAX));
      thre_pend  <= ~thre_clr & (thre_pend | thre_set);
      tx_prev    <= tx_elements_i;
      ier_thre_q <= ier_i[1];
    end
  end

  // Priority encode; enables gate only here, pending flags latch regardless
  always_comb begin
    iir_nxt = IIR_NONE;
    if (rls_pend && ier_i[2])       iir_nxt = IIR_RLS;
    else if (rda_cond && ier_i[0])  iir_nxt = IIR_RDA;
    else if (cti_pend && ier_i[0])  iir_nxt = IIR_CTI;
    else if (thre_pend && ier_i[1]) iir_nxt = IIR_THRE;
    else if (ms_pend && ier_i[3])   iir_nxt = IIR_MS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) iir_o <= IIR_NONE;
    else          iir_o <= iir_nxt;
  end

  assign interrupt_o = ~iir_o[0];

endmodule

// File: tb/tb_apb_uart_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_irq_ctrl
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural reference model of the interrupt controller.
// ---------------------------------------------------------------------------
module tb_apb_uart_irq_ctrl;

  localparam int D  = 16;
  localparam int TD = 16;
  localparam int TO = 40;

  logic       clk;
  logic       reset_n;
  logic [3:0] ier;
  logic       fifo_en;
  logic [1:0] trig;
  logic [4:0] rx_el;
  logic [4:0] tx_el;
  logic       rx_push, rx_pop, tx_push, bit_tick;
  logic       line_err, msr_change, lsr_rd, msr_rd, iir_rd;
  logic [3:0] iir;
  logic       irq;

  apb_uart_irq_ctrl #(
    .RX_FIFO_DEPTH(D), .TX_FIFO_DEPTH(TD), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ier_i(ier), .fifo_en_i(fifo_en),
    .trigger_level_i(trig), .rx_elements_i(rx_el), .tx_elements_i(tx_el),
    .rx_push_i(rx_push), .rx_pop_i(rx_pop), .tx_push_i(tx_push),
    .bit_tick_i(bit_tick), .line_err_i(line_err), .msr_change_i(msr_change),
    .lsr_rd_i(lsr_rd), .msr_rd_i(msr_rd), .iir_rd_i(iir_rd),
    .iir_o(iir), .interrupt_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit   m_rls, m_ms, m_cti, m_thre, m_ier1;
  int   m_cnt, m_txprev;
  logic [3:0] m_iir;

  function automatic int threshold(input int lvl);
    case (lvl)
      0: return 1;
      1: return D / 4;
      2: return D / 2;
      default: return D - 2;
    endcase
  endfunction

  task automatic model_reset();
    m_rls = 0; m_ms = 0; m_cti = 0; m_thre = 0; m_ier1 = 0;
    m_cnt = 0; m_txprev = 0; m_iir = 4'b0001;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit rda, rx_act, rls_n, ms_n, cti_n, thre_n;
    int cnt_n;
    logic [3:0] iir_n;
    rda = fifo_en ? (int'(rx_el) >= threshold(int'(trig))) : (rx_el != 0);
    if      (m_rls  && ier[2]) iir_n = 4'b0110;
    else if (rda    && ier[0]) iir_n = 4'b0100;
    else if (m_cti  && ier[0]) iir_n = 4'b1100;
    else if (m_thre && ier[1]) iir_n = 4'b0010;
    else if (m_ms   && ier[3]) iir_n = 4'b0000;
    else                       iir_n = 4'b0001;
    rx_act = rx_push || rx_pop || (rx_el == 0);
    rls_n  = line_err   || (m_rls && !lsr_rd);
    ms_n   = msr_change || (m_ms  && !msr_rd);
    cti_n  = rx_act ? 1'b0 : (m_cti || (m_cnt == TO));
    if (rx_act || !fifo_en) cnt_n = 0;
    else if (bit_tick)      cnt_n = (m_cnt + 1 > TO) ? TO : m_cnt + 1;
    else                    cnt_n = m_cnt;
    if (tx_push || (iir_rd && m_iir == 4'b0010)) thre_n = 0;
    else thre_n = m_thre || (tx_el == 0 && (m_txprev != 0 || (ier[1] && !m_ier1)));
    m_rls = rls_n; m_ms = ms_n; m_cti = cti_n; m_thre = thre_n; m_cnt = cnt_n;
    m_txprev = int'(tx_el); m_ier1 = ier[1]; m_iir = iir_n;
  endtask

  // One clock: model advance, edge, compare, drop single-cycle strobes
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("iir", iir, m_iir);
    chk("irq", {3'b0, irq}, {3'b0, ~m_iir[0]});
    rx_push = 0; rx_pop = 0; tx_push = 0; bit_tick = 0;
    line_err = 0; msr_change = 0; lsr_rd = 0; msr_rd = 0; iir_rd = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    #2;
    reset_n = 0;
    #1;
    chk("rst_iir", iir, 4'b0001);
    chk("rst_irq", {3'b0, irq}, 4'b0000);
    model_reset();
    #1;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; ier = 0; fifo_en = 0; trig = 0; rx_el = 0; tx_el = 0;
    rx_push = 0; rx_pop = 0; tx_push = 0; bit_tick = 0;
    line_err = 0; msr_change = 0; lsr_rd = 0; msr_rd = 0; iir_rd = 0;
    model_reset();
    #12;
    chk("reset_iir", iir, 4'b0001);
    chk("reset_irq", {3'b0, irq}, 4'b0000);
    reset_n = 1;
    step();

    // RLS visible for exactly one cycle
    ier = 4'b0100; line_err = 1; step();
    chk("rls_pre", iir, 4'b0001);
    lsr_rd = 1; step();
    chk("rls_on", iir, 4'b0110);
    step();
    chk("rls_off", iir, 4'b0001);

    // RDA threshold at trigger 2, and full FIFO at trigger 3
    ier = 4'b0001; fifo_en = 1; trig = 2;
    rx_el = 7; step(); chk("rda_7", iir, 4'b0001);
    rx_el = 8; step(); chk("rda_8", iir, 4'b0100);
    rx_el = 9; step(); chk("rda_9", iir, 4'b0100);
    trig = 3; rx_el = 16; step(); chk("rda_full", iir, 4'b0100);
    rx_el = 0; step(); chk("rda_empty", iir, 4'b0001);

    // Character timeout: counter hits 40, CTI latches, IIR one edge later
    trig = 2; rx_el = 2; step();
    for (int i = 0; i < TO; i++) begin bit_tick = 1; step(); end
    chk("cti_cnt", iir, 4'b0001);
    step(); step();
    chk("cti_on", iir, 4'b1100);
    rx_pop = 1; step(); step();
    chk("cti_pop", iir, 4'b0001);
    for (int i = 0; i < TO - 1; i++) begin bit_tick = 1; step(); end
    rx_push = 1; step();
    for (int i = 0; i < 4; i++) step();
    chk("cti_39", iir, 4'b0001);

    // All four sources pending, drained in priority order
    for (int i = 0; i < TO; i++) begin bit_tick = 1; step(); end
    ier = 4'b1111; line_err = 1; msr_change = 1; step();
    step(); step();
    chk("pri_rls", iir, 4'b0110);
    lsr_rd = 1; step(); step(); chk("pri_cti", iir, 4'b1100);
    rx_pop = 1; step(); step(); chk("pri_thre", iir, 4'b0010);
    iir_rd = 1; step(); step(); chk("pri_ms", iir, 4'b0000);
    msr_rd = 1; step(); step(); chk("pri_none", iir, 4'b0001);

    // THRE from enable rise after TX drain; tx_push on the rise suppresses it
    ier = 4'b0000; tx_el = 1; step();
    tx_el = 0; step(); step();
    ier = 4'b0010; step(); step();
    chk("thre_en", iir, 4'b0010);
    tx_push = 1; step(); step();
    chk("thre_push", iir, 4'b0001);
    ier = 4'b0000; step();
    ier = 4'b0010; tx_push = 1; step(); step();
    chk("thre_rise_push", iir, 4'b0001);

    // Reset while interrupts pending: nothing survives
    ier = 4'b0101; rx_el = 2;
    for (int i = 0; i < TO; i++) begin bit_tick = 1; step(); end
    line_err = 1; step(); step(); step();
    chk("pre_rst", iir, 4'b0110);
    async_reset();
    rx_el = 0; step(); step();
    chk("post_rst", iir, 4'b0001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0)  ier = 4'($urandom);
      if ($urandom_range(63) == 0) fifo_en = ~fifo_en;
      if ($urandom_range(31) == 0) trig = 2'($urandom);
      if ($urandom_range(47) == 0) rx_el = 5'($urandom_range(D));
      if ($urandom_range(15) == 0) tx_el = 5'($urandom_range(3) == 0 ? TD : $urandom_range(2));
      bit_tick   = ($urandom_range(1) == 0);
      rx_push    = ($urandom_range(79) == 0);
      rx_pop     = ($urandom_range(79) == 0);
      tx_push    = ($urandom_range(15) == 0);
      line_err   = ($urandom_range(31) == 0);
      lsr_rd     = ($urandom_range(7) == 0);
      msr_change = ($urandom_range(31) == 0);
      msr_rd     = ($urandom_range(7) == 0);
      iir_rd     = ($urandom_range(3) == 0);
      step();
      if ($urandom_range(599) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
